load_responder: RTL
===================

# load_responder

Memory-side responder for the accelerator's load phase. Receives per-word IFM and weight write requests (request strobe plus word address) issued by the control unit while it is in LOAD, and pairs each request with a data word from the matching DMA input stream. Writes the word into the shared on-chip feature/weight BRAM and returns a per-word `addr_valid` acknowledge. Counts completed words and flags when both regions are fully loaded.

## Interface
- `FIFO_DEPTH`, 4: request FIFO entries per channel (power of 2, ≥2).
- `IFM_WORDS`, 26912: IFM words per load (58·58·32 bytes / 4).
- `WGT_WORDS`, 72: weight words per load (288 bytes / 4).
- `WGT_BASE`, 16'h8000: BRAM word offset of the weight region.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `clear_i`  in  1  synchronous clear; same effect as reset.
- `wr_rd_req_IFM`  in  1  one IFM word request per high cycle.
- `wr_addr_IFM`  in  32  IFM word address.
- `wr_rd_req_Weight`  in  1  one weight word request per high cycle.
- `wr_addr_Weight`  in  32  weight word address.
- `ifm_data` / `ifm_valid` / `ifm_ready`  in/in/out  32/1/1  IFM DMA stream.
- `wgt_data` / `wgt_valid` / `wgt_ready`  in/in/out  32/1/1  weight DMA stream.
- `bram_we`  out  1  BRAM write strobe.
- `bram_addr`  out  16  BRAM word address.
- `bram_wdata`  out  32  BRAM write data.
- `addr_valid`  out  1  one-cycle acknowledge per completed write.
- `ifm_cnt`, `wgt_cnt`  out  16  completed words per channel, saturating.
- `load_done`  out  1  level; both counts reached their targets.
- `ovf_err`  out  1  sticky; a request arrived at a full FIFO.
- `addr_err`  out  1  sticky; out-of-range address (see Configuration).

## Operation
- Each high request cycle pushes its address into that channel's FIFO. No backpressure toward the requester. A push into a full FIFO is dropped and sets `ovf_err`. Push and pop in the same cycle on a full FIFO: both happen, nothing is dropped.
- A channel is eligible when its FIFO is non-empty and its stream `*_valid` is high.
- Round-robin arbiter, one grant per cycle:
  - Only one channel eligible: that channel wins.
  - Both eligible: the channel not granted last wins. After reset the last grant is weight, so IFM wins first.
- `*_ready` is combinational: high only for the granted channel. Handshake = valid & ready. A handshake pops the FIFO head.
- Address mapping:
  - IFM: `bram_addr = addr[15:0]`.
  - Weight: `bram_addr = WGT_BASE + addr[14:0]` (16-bit wrap).
- Write completion: `bram_we`, `bram_addr`, `bram_wdata` and `addr_valid` are registered from the handshake and are high together for exactly one cycle. The matching channel counter increments in that same cycle and saturates at 16'hFFFF.
- `load_done` = (`ifm_cnt` ≥ `IFM_WORDS`) && (`wgt_cnt` ≥ `WGT_WORDS`), registered. It stays high until reset or `clear_i`.
- Reset or `clear_i`: FIFOs emptied, arbiter pointer reset, all outputs 0 (`ifm_ready`/`wgt_ready` 0 since FIFOs are empty). Reset mid-transfer discards in-flight requests. No write is issued in the cycle after reset.

## Timing
- Request in cycle R: FIFO entry is visible in R+1. Earliest handshake is R+1. Earliest `bram_we`/`addr_valid` is R+2.
- Sustained throughput: 1 write/cycle total across both channels. With both channels saturated, grants alternate IFM, weight, IFM, …
- `load_done` rises one cycle after the completing write's counter update.
- Stream data not consumed (ready low) must be held by the source. The block never samples data without a handshake.

## Configuration
- `LOAD_RESP_ADDR_CHECK_EN` defined:
  - An IFM request with address ≥ `IFM_WORDS`, or a weight request with address ≥ `WGT_WORDS`, is dropped at push and sets `addr_err`.
  - The dropped request consumes no stream word.
- Undefined: no range check. Addresses are truncated as described in Operation, and `addr_err` is tied to 0.

## Structure
- Package `load_resp_pkg` holds:
  - channel select constants (`CH_IFM`=0, `CH_WGT`=1);
  - default `IFM_WORDS`, `WGT_WORDS`, `WGT_BASE`;
  - the BRAM address width (16) and data width (32).
- Sub-module `load_req_fifo`: synchronous FIFO with push, pop, full, empty and head outputs and synchronous clear. It is instantiated once per channel.
- Top level contains the arbiter, the write register stage, the counters and the flags.

## Test plan
- Reset, then 4 IFM requests at addresses 0..3 with `ifm_data` = A0..A3 always valid -> 4 writes to `bram_addr` 0..3 carrying A0..A3, each with `addr_valid`; first write 2 cycles after the first request; `ifm_cnt`=4.
- Requests and both streams held continuously on both channels -> writes alternate IFM/weight starting with IFM; weight word 0 written to 0x8000.
- 6 back-to-back IFM requests with `ifm_valid`=0 (FIFO_DEPTH 4) -> `ovf_err`=1 after the 5th request; once valid is raised, exactly 4 writes occur.
- Full load (26912 IFM + 72 weight words) -> `load_done` rises one cycle after the last write; `clear_i` drops it and zeroes both counters.
- With `LOAD_RESP_ADDR_CHECK_EN`, weight request at address 72 -> no write, `addr_err`=1, `wgt_ready` stays low.
- Assert `rst_n`=0 with 3 queued requests -> all outputs 0; no writes after release until new requests arrive.

Source files
------------

// File: rtl/load_resp_pkg.sv
// Shared definitions for the load-phase responder: channel identifiers,
// default load sizes, BRAM geometry and the weight address mapping.
package load_resp_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  localparam int          DEF_IFM_WORDS = 26912;
  localparam int          DEF_WGT_WORDS = 72;
  localparam logic [15:0] DEF_WGT_BASE  = 16'h8000;

  typedef enum logic {
    CH_IFM = 1'b0,
    CH_WGT = 1'b1
  } chan_e;

  // Weight words live above the base offset; only the low 15 address bits
  // select the word and the sum wraps at 16 bits.
  function automatic logic [ADDR_W-1:0] map_wgt_addr(input logic [ADDR_W-1:0] base,
                                                     input logic [31:0]       addr);
    return base + {1'b0, addr[14:0]};
  endfunction

endpackage

// File: rtl/load_req_fifo.sv
// Small synchronous request FIFO holding already-mapped BRAM word addresses.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module load_req_fifo
  import load_resp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ADDR_W
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [PTR_W:0]   count_q;
  logic             doPush, doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign head_o  = mem_q[rdPtr_q];
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (clear_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/load_responder.sv
// Load-phase memory responder: queues IFM and weight word requests, pairs
// each with a word from the matching DMA stream under round-robin
// arbitration, writes it to the shared BRAM and counts completed words.
// Optional range check on request addresses: LOAD_RESP_ADDR_CHECK_EN.
module load_responder
  import load_resp_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter int          IFM_WORDS  = DEF_IFM_WORDS,
  parameter int          WGT_WORDS  = DEF_WGT_WORDS,
  parameter logic [15:0] WGT_BASE   = DEF_WGT_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              wr_rd_req_IFM,
  input  logic [31:0]       wr_addr_IFM,
  input  logic              wr_rd_req_Weight,
  input  logic [31:0]       wr_addr_Weight,
  input  logic [DATA_W-1:0] ifm_data,
  input  logic              ifm_valid,
  output logic              ifm_ready,
  input  logic [DATA_W-1:0] wgt_data,
  input  logic              wgt_valid,
  output logic              wgt_ready,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic              addr_valid,
  output logic [15:0]       ifm_cnt,
  output logic [15:0]       wgt_cnt,
  output logic              load_done,
  output logic              ovf_err,
  output logic              addr_err
);

  localparam logic [15:0] IFM_TGT = 16'(IFM_WORDS);
  localparam logic [15:0] WGT_TGT = 16'(WGT_WORDS);

  logic              clr;
  logic              ifmInRange, wgtInRange;
  logic              ifmPush, wgtPush;
  logic [ADDR_W-1:0] ifmMapped, wgtMapped, ifmHead, wgtHead;
  logic              ifmFull, ifmEmpty, wgtFull, wgtEmpty;
  logic              ifmElig, wgtElig, grantIfm, grantWgt;
  logic              ovfHit, addrBad;

  chan_e             lastGrant_q, lastGrant_d;
  logic              bramWe_q, bramWe_d;
  logic [ADDR_W-1:0] bramAddr_q, bramAddr_d;
  logic [DATA_W-1:0] bramWdata_q, bramWdata_d;
  logic [15:0]       ifmCnt_q, ifmCnt_d, wgtCnt_q, wgtCnt_d;
  logic              loadDone_q, loadDone_d;
  logic              ovfErr_q, ovfErr_d;
  logic              addrErr_q, addrErr_d;

  assign clr = !rst_n || clear_i;

`ifdef LOAD_RESP_ADDR_CHECK_EN
  assign ifmInRange = (wr_addr_IFM < 32'(IFM_WORDS));
  assign wgtInRange = (wr_addr_Weight < 32'(WGT_WORDS));
`else
  assign ifmInRange = 1'b1;
  assign wgtInRange = 1'b1;
`endif

  assign ifmMapped = wr_addr_IFM[ADDR_W-1:0];
  assign wgtMapped = map_wgt_addr(WGT_BASE, wr_addr_Weight);
  assign ifmPush   = wr_rd_req_IFM && ifmInRange;
  assign wgtPush   = wr_rd_req_Weight && wgtInRange;
  assign addrBad   = (wr_rd_req_IFM && !ifmInRange) || (wr_rd_req_Weight && !wgtInRange);

  load_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ADDR_W)) u_ifm_fifo (
    .clk    (clk),
    .clear_i(clr),
    .push_i (ifmPush),
    .data_i (ifmMapped),
    .pop_i  (grantIfm),
    .full_o (ifmFull),
    .empty_o(ifmEmpty),
    .head_o (ifmHead)
  );

  load_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ADDR_W)) u_wgt_fifo (
    .clk    (clk),
    .clear_i(clr),
    .push_i (wgtPush),
    .data_i (wgtMapped),
    .pop_i  (grantWgt),
    .full_o (wgtFull),
    .empty_o(wgtEmpty),
    .head_o (wgtHead)
  );

  assign ifmElig   = !ifmEmpty && ifm_valid;
  assign wgtElig   = !wgtEmpty && wgt_valid;
  assign ifm_ready = grantIfm;
  assign wgt_ready = grantWgt;

  // A full FIFO drops the push unless its head leaves in the same cycle.
  assign ovfHit = (ifmPush && ifmFull && !grantIfm) || (wgtPush && wgtFull && !grantWgt);

  // Round-robin grant: a contested cycle goes to the channel not served last.
  always_comb begin
    grantIfm = 1'b0;
    grantWgt = 1'b0;
    if (ifmElig && (!wgtElig || lastGrant_q == CH_WGT)) begin
      grantIfm = 1'b1;
    end else if (wgtElig) begin
      grantWgt = 1'b1;
    end
  end

  // Next state of the write stage, counters and sticky flags.
  always_comb begin
    lastGrant_d = lastGrant_q;
    bramWe_d    = grantIfm || grantWgt;
    bramAddr_d  = bramAddr_q;
    bramWdata_d = bramWdata_q;
    ifmCnt_d    = ifmCnt_q;
    wgtCnt_d    = wgtCnt_q;
    if (grantIfm) begin
      lastGrant_d = CH_IFM;
      bramAddr_d  = ifmHead;
      bramWdata_d = ifm_data;
      if (ifmCnt_q != 16'hFFFF) ifmCnt_d = ifmCnt_q + 16'd1;
    end else if (grantWgt) begin
      lastGrant_d = CH_WGT;
      bramAddr_d  = wgtHead;
      bramWdata_d = wgt_data;
      if (wgtCnt_q != 16'hFFFF) wgtCnt_d = wgtCnt_q + 16'd1;
    end
    loadDone_d = loadDone_q || ((ifmCnt_q >= IFM_TGT) && (wgtCnt_q >= WGT_TGT));
    ovfErr_d   = ovfErr_q || ovfHit;
    addrErr_d  = addrErr_q || addrBad;
  end

  // State registers; reset and clear both return everything to idle.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      lastGrant_q <= CH_WGT;
      bramWe_q    <= 1'b0;
      bramAddr_q  <= '0;
      bramWdata_q <= '0;
      ifmCnt_q    <= '0;
      wgtCnt_q    <= '0;
      loadDone_q  <= 1'b0;
      ovfErr_q    <= 1'b0;
      addrErr_q   <= 1'b0;
    end else begin
      lastGrant_q <= lastGrant_d;
      bramWe_q    <= bramWe_d;
      bramAddr_q  <= bramAddr_d;
      bramWdata_q <= bramWdata_d;
      ifmCnt_q    <= ifmCnt_d;
      wgtCnt_q    <= wgtCnt_d;
      loadDone_q  <= loadDone_d;
      ovfErr_q    <= ovfErr_d;
      addrErr_q   <= addrErr_d;
    end
  end

  assign bram_we    = bramWe_q;
  assign addr_valid = bramWe_q;
  assign bram_addr  = bramAddr_q;
  assign bram_wdata = bramWdata_q;
  assign ifm_cnt    = ifmCnt_q;
  assign wgt_cnt    = wgtCnt_q;
  assign load_done  = loadDone_q;
  assign ovf_err    = ovfErr_q;
  assign addr_err   = addrErr_q;

endmodule
